// File: rtl/timer_seq_pkg.sv
// Shared definitions for the timer APB sequencer.
// Contents: timer register addresses, TCR bit positions, FSM state encodings,
// job completion status codes and a helper that builds TCR write words.
package timer_seq_pkg;

   localparam logic [7:0] ADDR_TDR = 8'h00;
   localparam logic [7:0] ADDR_TCR = 8'h01;
   localparam logic [7:0] ADDR_TSR = 8'h02;

   localparam int unsigned TCR_LOAD_BIT = 7;
   localparam int unsigned TCR_DIR_BIT  = 5;
   localparam int unsigned TCR_EN_BIT   = 4;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_TDR,
      S_WR_LOAD,
      S_WR_START,
      S_GAP,
      S_RD_TSR,
      S_WR_STOP,
      S_WR_CLR,
      S_FIN
   } seq_state_e;

   typedef enum logic [1:0] {
      X_IDLE,
      X_SETUP,
      X_ACCESS
   } xfer_state_e;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_ABORT   = 2'b01,
      ST_TIMEOUT = 2'b10,
      ST_SLVERR  = 2'b11
   } done_status_e;

   function automatic logic [7:0] tcr_word(input logic load, input logic down,
                                           input logic en, input logic [1:0] cks);
      logic [7:0] w;
      w               = '0;
      w[TCR_LOAD_BIT] = load;
      w[TCR_DIR_BIT]  = down;
      w[TCR_EN_BIT]   = en;
      w[1:0]          = cks;
      return w;
   endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// Single APB master transfer engine (SETUP then ACCESS until pready).
// Ports: i_clk/i_rst (sync active-high), i_start with i_addr/i_wdata/i_write
// request a transfer when idle; o_busy while a transfer is in flight;
// o_xfer_done pulses in the completing ACCESS cycle together with o_rdata and
// o_slverr; o_p* / i_p* are the APB bus signals.
module apb_master_xfer
   import timer_seq_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [7:0] i_addr,
   input  logic [7:0] i_wdata,
   input  logic       i_write,
   output logic       o_busy,
   output logic [7:0] o_rdata,
   output logic       o_slverr,
   output logic       o_xfer_done,
   output logic       o_psel,
   output logic       o_penable,
   output logic       o_pwrite,
   output logic [7:0] o_paddr,
   output logic [7:0] o_pwdata,
   input  logic [7:0] i_prdata,
   input  logic       i_pready,
   input  logic       i_pslverr
);

   xfer_state_e r_state, w_state_nxt;
   logic [7:0]  r_addr, r_wdata;
   logic        r_write;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= X_IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Address/data are latched once so they stay stable for the whole transfer.
         if (r_state == X_IDLE && i_start) begin
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_write <= i_write;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         X_IDLE:   if (i_start)  w_state_nxt = X_SETUP;
         X_SETUP:                w_state_nxt = X_ACCESS;
         X_ACCESS: if (i_pready) w_state_nxt = X_IDLE;
         default:                w_state_nxt = X_IDLE;
      endcase
   end

   assign o_psel      = (r_state != X_IDLE);
   assign o_penable   = (r_state == X_ACCESS);
   assign o_pwrite    = r_write;
   assign o_paddr     = r_addr;
   assign o_pwdata    = r_wdata;
   assign o_busy      = (r_state != X_IDLE);
   assign o_xfer_done = (r_state == X_ACCESS) && i_pready;
   assign o_slverr    = o_xfer_done && i_pslverr;
   assign o_rdata     = i_prdata;

endmodule

// File: rtl/timer_apb_sequencer.sv
// Runs a complete 8-bit timer job over APB from one command: write TDR, load,
// start, poll TSR for the selected flag, then stop the timer and clear TSR.
// Ports: pclk/preset (sync active-high); cmd_valid/cmd_ready handshake with
// cmd_tdr/cmd_down/cmd_cks; abort (level); APB master psel/penable/pwrite/
// paddr/pwdata/prdata/pready/pslverr; busy, done (1-cycle pulse) and
// done_status (held until the next done).
module timer_apb_sequencer
   import timer_seq_pkg::*;
#(
   parameter int unsigned POLL_GAP    = 16,
   parameter int unsigned TIMEOUT_CYC = 8192
) (
   input  logic       pclk,
   input  logic       preset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_tdr,
   input  logic       cmd_down,
   input  logic [1:0] cmd_cks,
   input  logic       abort,
   output logic       psel,
   output logic       penable,
   output logic       pwrite,
   output logic [7:0] paddr,
   output logic [7:0] pwdata,
   input  logic [7:0] prdata,
   input  logic       pready,
   input  logic       pslverr,
   output logic       busy,
   output logic       done,
   output logic [1:0] done_status
);

   localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
   localparam logic [15:0] TMO_LIM  = 16'(TIMEOUT_CYC);

   seq_state_e   r_state, w_state_nxt;
   logic [7:0]   r_tdr;
   logic         r_down;
   logic [1:0]   r_cks;
   logic         r_issued;
   logic [15:0]  r_gap, r_tmo;
   done_status_e r_job_st, w_job_st, r_done_st, w_fin_st;

   logic         w_start, w_write, w_is_xfer;
   logic [7:0]   w_addr, w_wdata;
   logic         w_xbusy, w_xdone, w_xerr;
   logic [7:0]   w_rdata;
   logic         w_flag, w_tmo_hit, w_gap_end;

   apb_master_xfer u_xfer (
      .i_clk       (pclk),
      .i_rst       (preset),
      .i_start     (w_start),
      .i_addr      (w_addr),
      .i_wdata     (w_wdata),
      .i_write     (w_write),
      .o_busy      (w_xbusy),
      .o_rdata     (w_rdata),
      .o_slverr    (w_xerr),
      .o_xfer_done (w_xdone),
      .o_psel      (psel),
      .o_penable   (penable),
      .o_pwrite    (pwrite),
      .o_paddr     (paddr),
      .o_pwdata    (pwdata),
      .i_prdata    (prdata),
      .i_pready    (pready),
      .i_pslverr   (pslverr)
   );

   // Transfer request per state; r_issued ensures one transfer per state visit,
   // and waiting for the engine to go idle yields the idle cycle between transfers.
   always_comb begin
      w_addr    = ADDR_TDR;
      w_wdata   = '0;
      w_write   = 1'b1;
      w_is_xfer = 1'b1;
      case (r_state)
         S_WR_TDR:   w_wdata = r_tdr;
         S_WR_LOAD:  begin w_addr = ADDR_TCR; w_wdata = tcr_word(1'b1, r_down, 1'b0, r_cks); end
         S_WR_START: begin w_addr = ADDR_TCR; w_wdata = tcr_word(1'b0, r_down, 1'b1, r_cks); end
         S_RD_TSR:   begin w_addr = ADDR_TSR; w_write = 1'b0; end
         S_WR_STOP:  begin w_addr = ADDR_TCR; w_wdata = tcr_word(1'b0, r_down, 1'b0, r_cks); end
         S_WR_CLR:   w_addr = ADDR_TSR;
         default:    w_is_xfer = 1'b0;
      endcase
   end

   assign w_start   = w_is_xfer && !r_issued && !w_xbusy;
   assign w_flag    = |(w_rdata & (r_down ? 8'h02 : 8'h01));
   assign w_tmo_hit = (r_tmo >= TMO_LIM);
   assign w_gap_end = (r_gap == GAP_LAST);

   // Priority at a transfer boundary: slave error, then flag, then abort, then timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_job_st    = r_job_st;
      w_fin_st    = r_job_st;
      case (r_state)
         S_IDLE: if (cmd_valid) begin
            w_state_nxt = S_WR_TDR;
            w_job_st    = ST_OK;
         end
         S_WR_TDR, S_WR_LOAD: if (w_xdone) begin
            if (w_xerr)     begin w_state_nxt = S_FIN; w_fin_st = ST_SLVERR; end
            else if (abort) begin w_state_nxt = S_FIN; w_fin_st = ST_ABORT; end
            else            w_state_nxt = (r_state == S_WR_TDR) ? S_WR_LOAD : S_WR_START;
         end
         S_WR_START: if (w_xdone) begin
            if (w_xerr)     begin w_state_nxt = S_FIN; w_fin_st = ST_SLVERR; end
            else if (abort) begin w_state_nxt = S_WR_STOP; w_job_st = ST_ABORT; end
            else            w_state_nxt = S_GAP;
         end
         S_GAP: begin
            if (abort)          begin w_state_nxt = S_WR_STOP; w_job_st = ST_ABORT; end
            else if (w_gap_end) w_state_nxt = S_RD_TSR;
         end
         S_RD_TSR: if (w_xdone) begin
            if (w_xerr)         begin w_state_nxt = S_FIN; w_fin_st = ST_SLVERR; end
            else if (w_flag)    begin w_state_nxt = S_WR_STOP; w_job_st = ST_OK; end
            else if (abort)     begin w_state_nxt = S_WR_STOP; w_job_st = ST_ABORT; end
            else if (w_tmo_hit) begin w_state_nxt = S_WR_STOP; w_job_st = ST_TIMEOUT; end
            else                w_state_nxt = S_GAP;
         end
         S_WR_STOP: if (w_xdone) begin
            if (w_xerr) begin w_state_nxt = S_FIN; w_fin_st = ST_SLVERR; end
            else        w_state_nxt = S_WR_CLR;
         end
         S_WR_CLR: if (w_xdone) begin
            w_state_nxt = S_FIN;
            if (w_xerr) w_fin_st = ST_SLVERR;
         end
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state   <= S_IDLE;
         r_tdr     <= '0;
         r_down    <= 1'b0;
         r_cks     <= '0;
         r_issued  <= 1'b0;
         r_gap     <= '0;
         r_tmo     <= '0;
         r_job_st  <= ST_OK;
         r_done_st <= ST_OK;
      end else begin
         r_state  <= w_state_nxt;
         r_job_st <= w_job_st;
         if (r_state == S_IDLE && cmd_valid) begin
            r_tdr  <= cmd_tdr;
            r_down <= cmd_down;
            r_cks  <= cmd_cks;
         end
         if (w_start)      r_issued <= 1'b1;
         else if (w_xdone) r_issued <= 1'b0;
         r_gap <= (r_state == S_GAP) ? r_gap + 16'd1 : '0;
         if (r_state == S_WR_START && w_xdone)
            r_tmo <= '0;
         else if ((r_state == S_GAP || r_state == S_RD_TSR) && !w_tmo_hit)
            r_tmo <= r_tmo + 16'd1;
         if (w_state_nxt == S_FIN && r_state != S_FIN)
            r_done_st <= w_fin_st;
      end
   end

   assign cmd_ready   = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_FIN);
   assign done_status = r_done_st;

endmodule
